// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving a 4:1 single-bit mux.
// Grants are bounded by MAX_HOLD so no requester starves.
module rr_mux_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       y
);

  localparam logic [7:0] LP_MAX = 8'(MAX_HOLD);

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_ptr;
  logic [1:0] w_ptr_nxt;
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic [3:0] r_gnt;
  logic [3:0] w_gnt_nxt;
  logic       r_valid;
  logic       w_valid_nxt;
  logic [7:0] r_hold_cnt;
  logic [7:0] w_hold_nxt;
  logic [1:0] w_win;
  logic       w_any;
  logic       w_keep;
  logic       w_new;

  // descending scan so the lowest offset from ptr wins
  always_comb begin
    w_any = 1'b0;
    w_win = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[r_ptr + 2'(i)]) begin
        w_any = 1'b1;
        w_win = r_ptr + 2'(i);
      end
    end
  end

  assign w_keep = (r_state == S_GRANT)
                & req[r_sel]
                & (r_hold_cnt < LP_MAX);
  assign w_new  = ~w_keep & w_any;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    w_valid_nxt = r_valid;
    w_hold_nxt  = r_hold_cnt;
    unique case (1'b1)
      w_keep: begin
        w_hold_nxt = r_hold_cnt + 8'd1;
      end
      w_new: begin
        w_state_nxt = S_GRANT;
        w_gnt_nxt   = 4'b0001 << w_win;
        w_sel_nxt   = w_win;
        w_valid_nxt = 1'b1;
        w_hold_nxt  = 8'd1;
        w_ptr_nxt   = w_win + 2'd1;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
        w_valid_nxt = 1'b0;
        w_hold_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ptr      <= 2'd0;
      r_sel      <= 2'd0;
      r_gnt      <= 4'b0000;
      r_valid    <= 1'b0;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_sel      <= w_sel_nxt;
      r_gnt      <= w_gnt_nxt;
      r_valid    <= w_valid_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = r_valid;
  assign y     = r_valid & din[r_sel];

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter.
// Two instances: MAX_HOLD=8 and MAX_HOLD=4.
module tb_rr_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] g8, g4;
  logic [1:0] s8, s4;
  logic       v8, v4;
  logic       y8, y4;
  logic       inv_on = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [3:0] f_req [9];
  logic [3:0] f_gnt [9];

  rr_mux_arbiter #(.MAX_HOLD(8)) u_d8 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(g8), .sel(s8), .valid(v8), .y(y8)
  );

  rr_mux_arbiter #(.MAX_HOLD(4)) u_d4 (
    .clk(clk), .rst(rst), .req(req), .din(din),
    .gnt(g4), .sel(s4), .valid(v4), .y(y4)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (inv_on) begin
      chk("inv_1hot8", 32'($onehot0(g8)), 1);
      chk("inv_1hot4", 32'($onehot0(g4)), 1);
      chk("inv_vld8", 32'(v8), 32'(|g8));
      chk("inv_vld4", 32'(v4), 32'(|g4));
      if (v8) begin
        chk("inv_gsel8", 32'(g8[s8]), 1);
        chk("inv_y8", 32'(y8), 32'(din[s8]));
      end
      if (v4) begin
        chk("inv_gsel4", 32'(g4[s4]), 1);
        chk("inv_y4", 32'(y4), 32'(din[s4]));
      end
      chk("inv_hold8", 32'(u_d8.r_hold_cnt <= 8'd8), 1);
      chk("inv_hold4", 32'(u_d4.r_hold_cnt <= 8'd4), 1);
    end
  end

  initial begin
    f_req = '{4'b1111, 4'b1111, 4'b1110, 4'b1111, 4'b1101,
              4'b1111, 4'b1011, 4'b1111, 4'b0111};
    f_gnt = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
              4'b0100, 4'b1000, 4'b1000, 4'b0001};

    rst = 1'b1;
    req = 4'b1111;
    din = 4'b0000;

    // reset held with all requests active
    for (int i = 0; i < 3; i++) begin
      step();
      inv_on = 1'b1;
      chk("rst_gnt", 32'(g8), 0);
      chk("rst_sel", 32'(s8), 0);
      chk("rst_vld", 32'(v8), 0);
      chk("rst_y", 32'(y8), 0);
    end
    rst = 1'b0;
    step();
    chk("first_gnt", 32'(g8), 32'h1);
    chk("first_sel", 32'(s8), 0);
    req = 4'b0000;
    step();
    chk("first_rel", 32'(v8), 0);

    // single requester with toggling data
    req = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk("one_gnt", 32'(g8), 32'h4);
      chk("one_sel", 32'(s8), 2);
      din[2] = i[0];
      #1;
      chk("one_y", 32'(y8), 32'(i[0]));
    end
    req = 4'b0000;
    din = 4'b1111;
    step();
    chk("one_idle", 32'(v8), 0);
    chk("one_ysel", 32'(s8), 2);
    chk("one_y0", 32'(y8), 0);

    // hold limit with two constant requesters
    req = 4'b0011;
    for (int c = 1; c <= 17; c++) begin
      step();
      chk("hold_gnt", 32'(g8),
          (c <= 8) ? 32'h1 : (c <= 16) ? 32'h2 : 32'h1);
    end
    req = 4'b0000;
    step();
    chk("hold_idle", 32'(v8), 0);

    // round-robin with one-cycle drops
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      req = f_req[k];
      step();
      chk("rr_gnt", 32'(g8), 32'(f_gnt[k]));
      chk("rr_vld", 32'(v8), 1);
    end

    // reset in the middle of a grant to requester 1
    req = 4'b0010;
    step();
    chk("mid_gnt", 32'(g8), 32'h2);
    req = 4'b1111;
    rst = 1'b1;
    step();
    chk("mid_rgnt", 32'(g8), 0);
    chk("mid_rsel", 32'(s8), 0);
    chk("mid_rvld", 32'(v8), 0);
    chk("mid_ry", 32'(y8), 0);
    rst = 1'b0;
    step();
    chk("mid_after", 32'(g8), 32'h1);

    // sole requester at expiry, MAX_HOLD=4
    rst = 1'b1;
    req = 4'b1000;
    step();
    rst = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      step();
      chk("sole_gnt", 32'(g4), 32'h8);
      chk("sole_cnt", 32'(u_d4.r_hold_cnt), 32'(((c - 1) % 4) + 1));
    end
    req = 4'b0000;
    step();
    chk("sole_idle", 32'(v4), 0);
    step();

    inv_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
